// File: rtl/operand_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_stage_pkg
// Purpose  : Shared widths and forward-select encoding for the ID operand fetch.
// Revision : 1.0  initial release
// ============================================================================
package operand_fetch_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_EXM = 2'd2
    } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_stage_if
// Purpose  : Decoder, register-file, bypass and ID/EX signals of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
interface operand_fetch_stage_if;
    import operand_fetch_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs;
    logic [REG_AW-1:0] in_rt;
    logic [REG_AW-1:0] in_rd;
    logic              in_is_load;
    logic              in_wen;
    logic [REG_AW-1:0] rf_read_reg1;
    logic [REG_AW-1:0] rf_read_reg2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic              exm_wen;
    logic [REG_AW-1:0] exm_reg;
    logic [DATA_W-1:0] exm_data;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic [REG_AW-1:0] out_rd;
    logic              out_wen;
    logic              out_is_load;

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_is_load, in_wen,
        input  rf_read_data1, rf_read_data2,
        input  exm_wen, exm_reg, exm_data, wb_wen, wb_reg, wb_data,
        input  out_ready,
        output in_ready, rf_read_reg1, rf_read_reg2,
        output out_valid, out_op1, out_op2, out_rd, out_wen, out_is_load
    );

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_is_load, in_wen,
        output rf_read_data1, rf_read_data2,
        output exm_wen, exm_reg, exm_data, wb_wen, wb_reg, wb_data,
        output out_ready,
        input  in_ready, rf_read_reg1, rf_read_reg2,
        input  out_valid, out_op1, out_op2, out_rd, out_wen, out_is_load
    );

endinterface
`default_nettype wire

// File: rtl/operand_fetch_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_mux
// Purpose  : Resolves one source operand from EX/MEM, WB or register file.
//            Optional macro OPFETCH_ZERO_REG_EN forces source 0 to read as 0.
// Revision : 1.0  initial release
// ============================================================================
module fwd_mux
    import operand_fetch_stage_pkg::*;
(
    input  wire logic [REG_AW-1:0] src,
    input  wire logic [DATA_W-1:0] rf_data,
    input  wire logic              exm_wen,
    input  wire logic [REG_AW-1:0] exm_reg,
    input  wire logic [DATA_W-1:0] exm_data,
    input  wire logic              wb_wen,
    input  wire logic [REG_AW-1:0] wb_reg,
    input  wire logic [DATA_W-1:0] wb_data,
    output logic      [DATA_W-1:0] operand,
    output fwd_sel_e               sel
);

    always_comb begin
        sel = FWD_RF;
        // Register 0 is never a forwarding destination
        if (exm_wen && (exm_reg != '0) && (exm_reg == src)) begin
            sel = FWD_EXM;
        end else if (wb_wen && (wb_reg != '0) && (wb_reg == src)) begin
            sel = FWD_WB;
        end

        case (sel)
            FWD_EXM: operand = exm_data;
            FWD_WB:  operand = wb_data;
            default: operand = rf_data;
        endcase

`ifdef OPFETCH_ZERO_REG_EN
        if (src == '0) begin
            operand = '0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_stage
// Purpose  : ID operand fetch with bypassing, load-use stall and ID/EX register.
//            Optional macro OPFETCH_ZERO_REG_EN (see fwd_mux).
// Revision : 1.0  initial release
// ============================================================================
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         reset,
    operand_fetch_stage_if.slave bus
);

    logic [DATA_W-1:0] op1_w, op2_w;
    fwd_sel_e          sel1_w, sel2_w;
    logic              hz_w, adv_w;

    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] out_op1_d, out_op1_q;
    logic [DATA_W-1:0] out_op2_d, out_op2_q;
    logic [REG_AW-1:0] out_rd_d, out_rd_q;
    logic              out_wen_d, out_wen_q;
    logic              out_is_load_d, out_is_load_q;

    assign bus.rf_read_reg1 = bus.in_rs;
    assign bus.rf_read_reg2 = bus.in_rt;

    fwd_mux u_fwd_rs (
        .src      (bus.in_rs),
        .rf_data  (bus.rf_read_data1),
        .exm_wen  (bus.exm_wen),
        .exm_reg  (bus.exm_reg),
        .exm_data (bus.exm_data),
        .wb_wen   (bus.wb_wen),
        .wb_reg   (bus.wb_reg),
        .wb_data  (bus.wb_data),
        .operand  (op1_w),
        .sel      (sel1_w)
    );

    fwd_mux u_fwd_rt (
        .src      (bus.in_rt),
        .rf_data  (bus.rf_read_data2),
        .exm_wen  (bus.exm_wen),
        .exm_reg  (bus.exm_reg),
        .exm_data (bus.exm_data),
        .wb_wen   (bus.wb_wen),
        .wb_reg   (bus.wb_reg),
        .wb_data  (bus.wb_data),
        .operand  (op2_w),
        .sel      (sel2_w)
    );

    // A load in ID/EX has no data until MEM, so a dependent reader must wait
    assign hz_w = out_valid_q && out_is_load_q && out_wen_q && (out_rd_q != '0)
                  && ((out_rd_q == bus.in_rs) || (out_rd_q == bus.in_rt))
                  && bus.in_valid;
    assign adv_w        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !hz_w && adv_w;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_rd_d      = out_rd_q;
        out_wen_d     = out_wen_q;
        out_is_load_d = out_is_load_q;
        if (adv_w) begin
            if (bus.in_valid && !hz_w) begin
                out_valid_d   = 1'b1;
                out_op1_d     = op1_w;
                out_op2_d     = op2_w;
                out_rd_d      = bus.in_rd;
                out_wen_d     = bus.in_wen;
                out_is_load_d = bus.in_is_load;
            end else begin
                out_valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_rd_q      <= '0;
            out_wen_q     <= 1'b0;
            out_is_load_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_rd_q      <= out_rd_d;
            out_wen_q     <= out_wen_d;
            out_is_load_q <= out_is_load_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_op1     = out_op1_q;
    assign bus.out_op2     = out_op2_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_wen     = out_wen_q;
    assign bus.out_is_load = out_is_load_q;

    // Select codes must stay within the three defined sources
    a_sel_legal: assert property (@(posedge clk) disable iff (reset)
        (sel1_w inside {FWD_RF, FWD_WB, FWD_EXM}) && (sel2_w inside {FWD_RF, FWD_WB, FWD_EXM}));

endmodule
`default_nettype wire

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID-stage operand fetch between the instruction decoder and the EX stage; drives the 32x32 register file's two read addresses and consumes its ReadData1/ReadData2.
- Adds EX/MEM and WB bypassing, load-use stall detection and bubble insertion, then registers a full ID/EX operand bundle under valid/ready handshake.

Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register address width (32 registers)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction available
- in_ready  out  1  stage accepts instruction this cycle
- in_rs  in  REG_AW  source register 1
- in_rt  in  REG_AW  source register 2
- in_rd  in  REG_AW  destination register
- in_is_load  in  1  instruction is a load
- in_wen  in  1  instruction writes a register
- rf_read_reg1  out  REG_AW  to register file ReadReg1 (= in_rs)
- rf_read_reg2  out  REG_AW  to register file ReadReg2 (= in_rt)
- rf_read_data1  in  DATA_W  from register file ReadData1
- rf_read_data2  in  DATA_W  from register file ReadData2
- exm_wen  in  1  EX/MEM result will be written
- exm_reg  in  REG_AW  EX/MEM destination
- exm_data  in  DATA_W  EX/MEM ALU result
- wb_wen  in  1  WB write this cycle (same as RegWrite)
- wb_reg  in  REG_AW  WB destination (same as WriteReg)
- wb_data  in  DATA_W  WB data (same as WriteData)
- out_valid  out  1  ID/EX bundle valid
- out_ready  in  1  EX accepts bundle
- out_op1  out  DATA_W  resolved operand 1
- out_op2  out  DATA_W  resolved operand 2
- out_rd  out  REG_AW  registered destination
- out_wen  out  1  registered write enable
- out_is_load  out  1  registered load flag

Behaviour:
- Reset, synchronous: out_valid, out_op1, out_op2, out_rd, out_wen and out_is_load all go to 0. Reset during a pending stall drops the held bundle; no bubble survives reset.
- rf_read_reg1/2 are combinational copies of in_rs/in_rt. The register file reads combinationally, so operands resolve in the same cycle.
- Operand select per source s (rs, rt), highest priority first:
  1. exm_wen && exm_reg==s selects exm_data.
  2. wb_wen && wb_reg==s selects wb_data. This covers the same-edge write that the register file does not yet show.
  3. Otherwise the register-file read data.
- Load-use hazard (hz): out_valid && out_is_load && out_wen && (out_rd==in_rs || out_rd==in_rt) && in_valid.
- in_ready = !hz && (!out_valid || out_ready).
- Output register update, only when (!out_valid || out_ready):
  - in_valid && !hz: load the bundle; out_valid becomes 1.
  - hz: load a bubble; out_valid becomes 0 for exactly one cycle, and the instruction stays on the input.
  - otherwise: out_valid becomes 0.
- When out_valid && !out_ready, every output holds stable. No input is consumed, even if forwarding sources change.
- Latency: 1 cycle from accept to out_valid. A load-use pair costs one extra bubble cycle.
- Throughput: 1 instruction per cycle with no hazards.
- Destination 0 is never matched for forwarding or hazard (exm_reg==0, wb_reg==0 and out_rd==0 are ignored).

Optional Feature:
- OPFETCH_ZERO_REG_EN
- Defined: a source index of 0 yields operand 0, overriding every forward and the register-file value. Required because the register file initialises to 32'hFFFFFFFF.
- Undefined: register 0 reads whatever the register file returns; the forwarding exclusion for index 0 still applies.

Decomposition:
- Shared package: DATA_W and REG_AW constants, plus the forward-select encoding (FWD_RF=0, FWD_WB=1, FWD_EXM=2).
- One sub-module, fwd_mux, instantiated twice (one per source): inputs are the source index, the register-file data and both forward ports; outputs are the resolved operand and the select code.

Test Plan:
- Reset with out_valid=1 held: assert reset 1 cycle, then check out_valid=0 and all outputs 0 next edge.
- WB bypass: wb_wen=1, wb_reg=5, wb_data=0x1234, in_rs=5, rf_read_data1=0xFFFFFFFF. Expect out_op1=0x1234 one cycle later.
- Priority: EX/MEM and WB both target reg 7, with exm_data=0xA and wb_data=0xB. Expect out_op2=0xA.
- Load-use: issue lw to r3, then an add reading r3 (in_rt=3). Expect in_ready=0 for 1 cycle and out_valid=0 for 1 cycle, then the add is accepted.
- Backpressure: out_ready=0 for 3 cycles while the forward data changes. Outputs stay bit-identical and in_ready=0.
- With OPFETCH_ZERO_REG_EN: in_rs=0 and rf_read_data1=0xFFFFFFFF give out_op1=0. Without it, out_op1=0xFFFFFFFF.
